// File: rtl/mem_access_if.sv
// mem_access_if: byte-serial memory bus between the MEM stage and memory
interface mem_access_if;
   logic        req;
   logic        wr;
   logic [31:0] addr;
   logic [7:0]  dout;
   logic [7:0]  din;
   logic        ack;
   modport master (output req, wr, addr, dout, input din, ack);
   modport slave (input req, wr, addr, dout, output din, ack);
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM stage executing loads/stores one byte at a time over an 8-bit bus
module mem_access (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   stall,
   input  logic [4:0]   ex_exec_in,
   input  logic [31:0]  ex_alu_in,
   input  logic [31:0]  ex_rs2_in,
   input  logic [4:0]   ex_rdest_in,
   input  logic         ex_we_in,
   mem_access_if.master bus,
   output logic         mem_stall_req,
   output logic [31:0]  mem_wdata_out,
   output logic [4:0]   mem_rdest_out,
   output logic         mem_we_out
);
   localparam logic [4:0] LB = 5'h10, LH = 5'h11, LW = 5'h12, LBU = 5'h13,
                          LHU = 5'h14, SB = 5'h15, SH = 5'h16, SW = 5'h17;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_nxt;
   logic [4:0] op, rdest;
   logic [31:0] base, sdata, asm, asm_nxt, ld;
   logic we, ex_mem, store, last;
   logic [1:0] idx, last_idx;
   logic unused;
   assign unused = ^{stall[5], stall[3:0]};
   assign ex_mem = ex_exec_in inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
   assign store = op inside {SB, SH, SW};
   assign last_idx = op inside {LW, SW} ? 2'd3 : op inside {LH, LHU, SH} ? 2'd1 : 2'd0;
   assign last = idx == last_idx;
   // merge the arriving byte so the final byte can be written back on its own ack edge
   assign asm_nxt = (asm & ~(32'hFF << {idx, 3'b0})) | ({24'b0, bus.din} << {idx, 3'b0});
   assign ld = op == LB  ? {{24{asm_nxt[7]}}, asm_nxt[7:0]}
             : op == LH  ? {{16{asm_nxt[15]}}, asm_nxt[15:0]}
             : op == LBU ? {24'b0, asm_nxt[7:0]}
             : op == LHU ? {16'b0, asm_nxt[15:0]}
             : asm_nxt;
   assign bus.req = state == ACCESS;
   assign bus.wr = bus.req && store;
   assign bus.addr = base + {30'b0, idx};
   assign bus.dout = 8'(sdata >> {idx, 3'b0});
   assign mem_stall_req = state == ACCESS || (state == IDLE && ex_mem);
   always_comb
      state_nxt = state == IDLE   ? (ex_mem && !stall[4] ? ACCESS : IDLE)
                : state == ACCESS ? (bus.ack && last ? DONE : ACCESS)
                : IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         op <= '0;
         base <= '0;
         sdata <= '0;
         rdest <= '0;
         we <= 1'b0;
         idx <= '0;
         asm <= '0;
         mem_wdata_out <= '0;
         mem_rdest_out <= '0;
         mem_we_out <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && !stall[4]) begin
            if (ex_mem) begin
               op <= ex_exec_in;
               base <= ex_alu_in;
               sdata <= ex_rs2_in;
               rdest <= ex_rdest_in;
               we <= ex_we_in;
               idx <= '0;
               asm <= '0;
            end
            mem_wdata_out <= ex_mem ? 32'd0 : ex_alu_in;
            mem_rdest_out <= ex_mem ? 5'd0 : ex_rdest_in;
            mem_we_out <= !ex_mem && ex_we_in;
         end else if (state == ACCESS && bus.ack) begin
            if (!store) asm <= asm_nxt;
            idx <= idx + 2'd1;
            if (last) begin
               mem_wdata_out <= store ? 32'd0 : ld;
               mem_rdest_out <= rdest;
               mem_we_out <= we && !store;
            end
         end else if (state != IDLE) begin
            mem_wdata_out <= '0;
            mem_rdest_out <= '0;
            mem_we_out <= 1'b0;
         end
      end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed stimulus against a transaction-level model of the MEM stage
module tb_mem_access;
   localparam logic [4:0] NOP = 5'h00, ADD = 5'h01, LB = 5'h10, LH = 5'h11, LW = 5'h12,
                          LBU = 5'h13, LHU = 5'h14, SB = 5'h15, SH = 5'h16, SW = 5'h17;
   logic clk = 0, rst = 1, we = 0;
   logic [5:0] stall = 0;
   logic [4:0] exec = 0, rdest = 0;
   logic [31:0] alu = 0, rs2 = 0;
   logic stall_req, we_o;
   logic [31:0] wdata;
   logic [4:0] rdest_o;
   mem_access_if bus();
   mem_access dut (
      .clk(clk), .rst(rst), .stall(stall), .ex_exec_in(exec), .ex_alu_in(alu),
      .ex_rs2_in(rs2), .ex_rdest_in(rdest), .ex_we_in(we), .bus(bus),
      .mem_stall_req(stall_req), .mem_wdata_out(wdata), .mem_rdest_out(rdest_o),
      .mem_we_out(we_o)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   bit chk_on = 0, late_ack = 0, seen = 0;
   logic [31:0] m_wdata = 0, m_addr = 0;
   logic [4:0] m_rdest = 0;
   logic m_we = 0, m_stall = 0, m_req = 0, m_wr = 0;
   logic [7:0] m_dout = 0;
   bit [7:0] mem [bit [31:0]];

   function automatic bit [7:0] mem_rd(bit [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] load_val(logic [4:0] op, logic [31:0] a);
      int unsigned b0, b1, b2, b3, h;
      b0 = mem_rd(a); b1 = mem_rd(a + 1); b2 = mem_rd(a + 2); b3 = mem_rd(a + 3);
      h = b0 + 256 * b1;
      case (op)
         LB: return b0 >= 128 ? 32'(b0) - 32'd256 : 32'(b0);
         LBU: return 32'(b0);
         LH: return h >= 32768 ? 32'(h) - 32'd65536 : 32'(h);
         LHU: return 32'(h);
         LW: return 32'(b0 + 256 * b1 + 65536 * b2 + 16777216 * b3);
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // memory: acks each byte one cycle after its request, optionally injects a stray ack
   initial begin
      bus.ack = 0;
      bus.din = 0;
      forever begin
         @(posedge clk);
         #2;
         if (late_ack) begin
            bus.ack = 1; bus.din = 8'h5A; late_ack = 0;
         end else if (bus.ack) begin
            bus.ack = 0; seen = bus.req;
         end else if (bus.req && seen) begin
            bus.ack = 1; bus.din = mem_rd(bus.addr); seen = 0;
            if (bus.wr) mem[bus.addr] = bus.dout;
         end else seen = bus.req;
      end
   end

   always @(negedge clk)
      if (chk_on) begin
         check("wb_wdata", wdata, m_wdata);
         check("wb_rdest", 32'(rdest_o), 32'(m_rdest));
         check("wb_we", 32'(we_o), 32'(m_we));
         check("stall_req", 32'(stall_req), 32'(m_stall));
         check("mem_req", 32'(bus.req), 32'(m_req));
         if (m_req) begin
            check("mem_addr", bus.addr, m_addr);
            check("mem_wr", 32'(bus.wr), 32'(m_wr));
            if (m_wr) check("mem_dout", 32'(bus.dout), 32'(m_dout));
         end
      end

   task automatic pt_op(input logic [4:0] op, input logic [31:0] a, input logic [4:0] rd_,
                        input logic w, input int hold);
      exec = op; alu = a; rdest = rd_; we = w; m_stall = 0; m_req = 0;
      stall = hold > 0 ? 6'h3F : 6'h2F;
      repeat (hold) begin @(posedge clk); #1; end
      stall = 6'h2F;
      @(posedge clk); #1;
      m_wdata = a; m_rdest = rd_; m_we = w;
   endtask

   task automatic mem_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd_, input logic w, input int rst_at,
                         output logic [31:0] res);
      int n;
      bit st;
      n = (op inside {LW, SW}) ? 4 : (op inside {LH, LHU, SH}) ? 2 : 1;
      st = op inside {SB, SH, SW};
      res = st ? 32'd0 : load_val(op, a);
      exec = op; alu = a; rs2 = d; rdest = rd_; we = w; stall = 0; m_stall = 1; m_req = 0;
      @(posedge clk); #1;
      m_wdata = 0; m_rdest = 0; m_we = 0; stall = 6'h10;
      for (int k = 0; k < n; k++) begin
         m_req = 1; m_addr = a + 32'(k); m_wr = st; m_dout = 8'(d >> (8 * k));
         @(posedge clk); #1;
         @(posedge clk); #1;
         if (k == rst_at) begin
            m_addr = a + 32'(k + 1); m_dout = 8'(d >> (8 * (k + 1)));
            rst = 1;
            @(posedge clk); #1;
            rst = 0; exec = NOP; alu = 0; rs2 = 0; rdest = 0; we = 0; stall = 0;
            m_req = 0; m_stall = 0; late_ack = 1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            return;
         end
      end
      m_req = 0; m_stall = 0; m_wdata = res; m_rdest = rd_; m_we = w && !st;
      @(posedge clk); #1;
      m_wdata = 0; m_rdest = 0; m_we = 0;
      exec = NOP; alu = 0; rs2 = 0; rdest = 0; we = 0; stall = 0;
   endtask

   initial begin
      logic [31:0] r;
      mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
      mem[32'h20] = 8'h80; mem[32'h31] = 8'h34; mem[32'h32] = 8'h92;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wdata", wdata, 32'h0);
      check("rst_we", 32'(we_o), 32'h0);
      check("rst_req", 32'(bus.req), 32'h0);
      rst = 0; chk_on = 1;
      pt_op(ADD, 32'h1234, 5'd5, 1'b1, 0);
      check("add_wdata_lit", wdata, 32'h1234);
      check("add_rdest_lit", 32'(rdest_o), 32'd5);
      mem_op(LW, 32'h100, 32'h0, 5'd9, 1'b1, -1, r);
      check("lw_lit", r, 32'h1234_5678);
      mem_op(LB, 32'h20, 32'h0, 5'd3, 1'b1, -1, r);
      check("lb_lit", r, 32'hFFFF_FF80);
      mem_op(LBU, 32'h20, 32'h0, 5'd4, 1'b1, -1, r);
      check("lbu_lit", r, 32'h0000_0080);
      mem_op(LH, 32'h31, 32'h0, 5'd10, 1'b1, -1, r);
      check("lh_lit", r, 32'hFFFF_9234);
      mem_op(LHU, 32'h31, 32'h0, 5'd11, 1'b1, -1, r);
      check("lhu_lit", r, 32'h0000_9234);
      mem_op(SH, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd4, 1'b1, -1, r);
      check("sh_byte0", 32'(mem_rd(32'hFFFF_FFFF)), 32'hDD);
      check("sh_byte1_wrap", 32'(mem_rd(32'h0)), 32'hCC);
      mem_op(SB, 32'h40, 32'h1234_56EE, 5'd2, 1'b1, -1, r);
      check("sb_byte", 32'(mem_rd(32'h40)), 32'hEE);
      check("sb_only_one", 32'(mem_rd(32'h41)), 32'h0);
      mem_op(SW, 32'h50, 32'h0102_0304, 5'd1, 1'b0, -1, r);
      mem_op(LW, 32'h50, 32'h0, 5'd12, 1'b1, -1, r);
      check("sw_lw_lit", r, 32'h0102_0304);
      pt_op(ADD, 32'h55, 5'd7, 1'b1, 0);
      pt_op(ADD, 32'h99, 5'd8, 1'b1, 2);
      check("hold_then_load_lit", wdata, 32'h99);
      pt_op(ADD, 32'h77, 5'd13, 1'b0, 0);
      mem_op(SW, 32'h60, 32'hCAFE_BABE, 5'd6, 1'b1, 0, r);
      check("rst_sw_byte0", 32'(mem_rd(32'h60)), 32'hBE);
      check("rst_sw_byte1", 32'(mem_rd(32'h61)), 32'h0);
      mem_op(LB, 32'h60, 32'h0, 5'd14, 1'b1, -1, r);
      check("lb_after_rst_lit", r, 32'hFFFF_FFBE);
      chk_on = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
